// File: rtl/carfield_periph_apb_demux.sv
// Purpose  : APB 1-to-N demux for the peripheral window; decodes the upstream address against
//            per-slave base/size windows and runs one registered APB transfer to the selected slave.
// Latency  : first upstream access cycle + 3 for a zero-wait hit, + 1 for an unmapped address.
// Backpress: upstream is held (s_pready_o=0) until the slave answers. A slave stalled for
//            TimeoutCycles ACCESS cycles, or an unmapped address, is answered locally with PSLVERR.
// Ports    : clk_i/rst_i           clock, synchronous active-high reset
//            s_p*                  upstream APB completer port
//            m_p*                  downstream APB requester port: one-hot psel, shared ctrl/data,
//                                  per-slave prdata/pready/pslverr
//            timeout_o             one-cycle pulse, coincident with the RESP cycle of a timed-out transfer
//            err_cnt_o             saturating count of decode errors plus timeouts
module carfield_periph_apb_demux #(
  parameter int unsigned NumSlaves = 5,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter logic [NumSlaves-1:0][AddrWidth-1:0] SlaveBase = {
    32'h2000_9000, 32'h2000_7000, 32'h2000_5000, 32'h2000_4000, 32'h2000_1000},
  parameter logic [NumSlaves-1:0][AddrWidth-1:0] SlaveSize = {5{32'h0000_1000}},
  parameter int unsigned TimeoutCycles = 64,
  parameter logic [DataWidth-1:0] ErrData = 32'hBADC_AB1E
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           s_psel_i,
  input  logic                           s_penable_i,
  input  logic                           s_pwrite_i,
  input  logic [AddrWidth-1:0]           s_paddr_i,
  input  logic [DataWidth-1:0]           s_pwdata_i,
  input  logic [DataWidth/8-1:0]         s_pstrb_i,
  output logic [DataWidth-1:0]           s_prdata_o,
  output logic                           s_pready_o,
  output logic                           s_pslverr_o,
  output logic [NumSlaves-1:0]           m_psel_o,
  output logic                           m_penable_o,
  output logic                           m_pwrite_o,
  output logic [AddrWidth-1:0]           m_paddr_o,
  output logic [DataWidth-1:0]           m_pwdata_o,
  output logic [DataWidth/8-1:0]         m_pstrb_o,
  input  logic [NumSlaves*DataWidth-1:0] m_prdata_i,
  input  logic [NumSlaves-1:0]           m_pready_i,
  input  logic [NumSlaves-1:0]           m_pslverr_i,
  output logic                           timeout_o,
  output logic [15:0]                    err_cnt_o
);

  localparam int unsigned IdxW  = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;
  localparam int unsigned CntW  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam bit          TmoEn = (TimeoutCycles != 0);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e                 r_state, w_state_nxt;
  logic [AddrWidth-1:0]   r_paddr;
  logic [DataWidth-1:0]   r_pwdata;
  logic [DataWidth/8-1:0] r_pstrb;
  logic                   r_pwrite;
  logic [IdxW-1:0]        r_idx;
  logic [CntW-1:0]        r_cnt;
  logic [DataWidth-1:0]   r_prdata;
  logic                   r_pslverr;
  logic                   r_timeout;
  logic [15:0]            r_err_cnt;

  logic                   w_capture;
  logic                   w_hit;
  logic [IdxW-1:0]        w_hit_idx;
  logic                   w_sel_pready;
  logic                   w_sel_pslverr;
  logic [DataWidth-1:0]   w_sel_prdata;
  logic                   w_tmo_fire;
  logic                   w_active;

  assign w_capture = s_psel_i && s_penable_i;

  // Address decode. The limit is formed one bit wider so a window ending at the top of the
  // address space does not wrap. Scanning from the top down leaves the lowest matching index.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NumSlaves - 1; i >= 0; i--) begin
      if (({1'b0, s_paddr_i} >= {1'b0, SlaveBase[i]}) &&
          ({1'b0, s_paddr_i} <  ({1'b0, SlaveBase[i]} + {1'b0, SlaveSize[i]}))) begin
        w_hit     = 1'b1;
        w_hit_idx = IdxW'(i);
      end
    end
  end

  // Response lane of the latched slave.
  always_comb begin
    w_sel_pready  = 1'b0;
    w_sel_pslverr = 1'b0;
    w_sel_prdata  = '0;
    for (int i = 0; i < NumSlaves; i++) begin
      if (r_idx == IdxW'(i)) begin
        w_sel_pready  = m_pready_i[i];
        w_sel_pslverr = m_pslverr_i[i];
        w_sel_prdata  = m_prdata_i[i*DataWidth +: DataWidth];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmo_fire  = 1'b0;
    unique case (r_state)
      IDLE:   if (w_capture) w_state_nxt = w_hit ? SETUP : RESP;
      SETUP:  w_state_nxt = ACCESS;
      ACCESS: begin
        // A ready in the last allowed cycle takes priority over the timeout.
        if (w_sel_pready) begin
          w_state_nxt = RESP;
        end else if (TmoEn && (r_cnt == CntLast)) begin
          w_state_nxt = RESP;
          w_tmo_fire  = 1'b1;
        end
      end
      RESP:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_pwrite  <= 1'b0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
      r_timeout <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_timeout <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_capture) begin
            r_paddr  <= s_paddr_i;
            r_pwdata <= s_pwdata_i;
            r_pstrb  <= s_pstrb_i;
            r_pwrite <= s_pwrite_i;
            r_idx    <= w_hit_idx;
            r_cnt    <= '0;
            if (w_hit) begin
              r_pslverr <= 1'b0;
              r_prdata  <= '0;
            end else begin
              r_pslverr <= 1'b1;
              r_prdata  <= ErrData;
              if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            end
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_sel_pready) begin
            r_prdata  <= w_sel_prdata;
            r_pslverr <= w_sel_pslverr;
          end else if (w_tmo_fire) begin
            r_prdata  <= ErrData;
            r_pslverr <= 1'b1;
            r_timeout <= 1'b1;
            if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_active = (r_state == SETUP) || (r_state == ACCESS);

  always_comb begin
    m_psel_o = '0;
    for (int i = 0; i < NumSlaves; i++) begin
      m_psel_o[i] = w_active && (r_idx == IdxW'(i));
    end
  end

  assign m_penable_o = (r_state == ACCESS);
  assign m_pwrite_o  = r_pwrite;
  assign m_paddr_o   = r_paddr;
  assign m_pwdata_o  = r_pwdata;
  assign m_pstrb_o   = r_pstrb;

  // Read data is only presented alongside pready, and never for writes.
  assign s_pready_o  = (r_state == RESP);
  assign s_pslverr_o = (r_state == RESP) && r_pslverr;
  assign s_prdata_o  = ((r_state == RESP) && !r_pwrite) ? r_prdata : '0;

  assign timeout_o   = r_timeout;
  assign err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_carfield_periph_apb_demux.sv
module tb_carfield_periph_apb_demux;

  localparam int NS = 5;
  localparam int DW = 32;
  localparam int TMO = 64;
  localparam logic [31:0] ERR_DATA = 32'hBADC_AB1E;

  logic           clk = 1'b0;
  logic           rst_i;
  logic           s_psel, s_penable, s_pwrite;
  logic [31:0]    s_paddr, s_pwdata;
  logic [3:0]     s_pstrb;
  logic [31:0]    s_prdata_o;
  logic           s_pready_o, s_pslverr_o;
  logic [NS-1:0]  m_psel_o;
  logic           m_penable_o, m_pwrite_o;
  logic [31:0]    m_paddr_o, m_pwdata_o;
  logic [3:0]     m_pstrb_o;
  logic [NS*DW-1:0] m_prdata;
  logic [NS-1:0]  m_pready, m_pslverr;
  logic           timeout_o;
  logic [15:0]    err_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_errcnt = 0;

  always #5 clk = ~clk;

  carfield_periph_apb_demux dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .s_psel_i    (s_psel),
    .s_penable_i (s_penable),
    .s_pwrite_i  (s_pwrite),
    .s_paddr_i   (s_paddr),
    .s_pwdata_i  (s_pwdata),
    .s_pstrb_i   (s_pstrb),
    .s_prdata_o  (s_prdata_o),
    .s_pready_o  (s_pready_o),
    .s_pslverr_o (s_pslverr_o),
    .m_psel_o    (m_psel_o),
    .m_penable_o (m_penable_o),
    .m_pwrite_o  (m_pwrite_o),
    .m_paddr_o   (m_paddr_o),
    .m_pwdata_o  (m_pwdata_o),
    .m_pstrb_o   (m_pstrb_o),
    .m_prdata_i  (m_prdata),
    .m_pready_i  (m_pready),
    .m_pslverr_i (m_pslverr),
    .timeout_o   (timeout_o),
    .err_cnt_o   (err_cnt_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory map of the peripheral window.
  function automatic logic [31:0] base_of(input int i);
    case (i)
      0: return 32'h2000_1000;
      1: return 32'h2000_4000;
      2: return 32'h2000_5000;
      3: return 32'h2000_7000;
      default: return 32'h2000_9000;
    endcase
  endfunction

  function automatic int decode(input logic [31:0] addr);
    longint a;
    longint b;
    a = longint'(addr);
    for (int i = 0; i < NS; i++) begin
      b = longint'(base_of(i));
      if (a >= b && a < b + 64'h1000) return i;
    end
    return -1;
  endfunction

  task automatic rand_lanes();
    for (int i = 0; i < NS; i++) m_prdata[i*DW +: DW] = $urandom;
    m_pready  = NS'($urandom_range(0, 31));
    m_pslverr = NS'($urandom_range(0, 31));
  endtask

  // One upstream transfer. k = ACCESS cycle (1-based) on which the selected slave raises pready.
  task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int k, input logic [31:0] rdata,
                      input bit serr, input bit abort, input string tag);
    int idx, exp_lat, exp_acc, n, acc, to_cnt;
    bit exp_err, exp_to, done;
    logic [31:0] exp_data, got_addr, got_wdata, got_rdata;
    logic [3:0]  got_strb;
    logic [NS-1:0] exp_sel, sel_or, sel_resp;
    bit got_wr, got_err;

    idx = decode(addr);
    exp_to = 0;
    exp_sel = '0;
    if (idx < 0) begin
      exp_lat = 1; exp_acc = 0; exp_err = 1; exp_data = wr ? 32'h0 : ERR_DATA;
      if (exp_errcnt < 65535) exp_errcnt++;
    end else begin
      exp_sel[idx] = 1'b1;
      if (k <= TMO) begin
        exp_lat = 2 + k; exp_acc = k; exp_err = serr; exp_data = wr ? 32'h0 : rdata;
      end else begin
        exp_lat = 2 + TMO; exp_acc = TMO; exp_err = 1; exp_to = 1;
        exp_data = wr ? 32'h0 : ERR_DATA;
        if (exp_errcnt < 65535) exp_errcnt++;
      end
    end

    @(negedge clk);
    s_psel = 1; s_penable = 0; s_paddr = addr; s_pwrite = wr; s_pwdata = wdata; s_pstrb = strb;
    @(negedge clk);
    s_penable = 1;
    n = 0; acc = 0; to_cnt = 0; done = 0; sel_or = '0; sel_resp = '1;
    got_addr = '0; got_wdata = '0; got_strb = '0; got_wr = 0; got_rdata = '0; got_err = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      rand_lanes();
      sel_or |= m_psel_o;
      if (timeout_o) to_cnt++;
      if (m_penable_o && m_psel_o != '0) begin
        acc++;
        if (acc == 1) begin
          got_addr = m_paddr_o; got_wdata = m_pwdata_o; got_strb = m_pstrb_o; got_wr = m_pwrite_o;
        end
      end
      if (idx >= 0) begin
        m_pready[idx] = (m_penable_o && acc == k);
        m_prdata[idx*DW +: DW] = rdata;
        m_pslverr[idx] = serr;
      end
      if (s_pready_o) begin
        done = 1;
        got_rdata = s_prdata_o;
        got_err = s_pslverr_o;
        sel_resp = m_psel_o;
      end
      if (abort && n == 1) begin
        s_psel = 0; s_penable = 0;
      end
    end
    s_psel = 0; s_penable = 0; m_pready = '0;
    check({tag, ":done"}, 64'(done), 64'd1);
    check({tag, ":latency"}, 64'(n), 64'(exp_lat));
    check({tag, ":prdata"}, 64'(got_rdata), 64'(exp_data));
    check({tag, ":pslverr"}, 64'(got_err), 64'(exp_err));
    check({tag, ":psel_seen"}, 64'(sel_or), 64'(exp_sel));
    check({tag, ":psel_resp"}, 64'(sel_resp), 64'd0);
    check({tag, ":access_cycles"}, 64'(acc), 64'(exp_acc));
    check({tag, ":timeout_pulses"}, 64'(to_cnt), 64'(exp_to));
    if (idx >= 0) begin
      check({tag, ":paddr"}, 64'(got_addr), 64'(addr));
      check({tag, ":pwrite"}, 64'(got_wr), 64'(wr));
      check({tag, ":pstrb"}, 64'(got_strb), 64'(strb));
      if (wr) check({tag, ":pwdata"}, 64'(got_wdata), 64'(wdata));
    end
    @(negedge clk);
    check({tag, ":pready_one_cycle"}, 64'(s_pready_o), 64'd0);
    check({tag, ":err_cnt"}, 64'(err_cnt_o), 64'(exp_errcnt));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int acc, k, s, r;
    logic [31:0] addr;
    logic [NS-1:0] pr_or;

    rst_i = 1; s_psel = 0; s_penable = 0; s_pwrite = 0;
    s_paddr = '0; s_pwdata = '0; s_pstrb = '0;
    m_prdata = '0; m_pready = '0; m_pslverr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst:s_pready", 64'(s_pready_o), 64'd0);
    check("rst:s_pslverr", 64'(s_pslverr_o), 64'd0);
    check("rst:s_prdata", 64'(s_prdata_o), 64'd0);
    check("rst:m_psel", 64'(m_psel_o), 64'd0);
    check("rst:m_penable", 64'(m_penable_o), 64'd0);
    check("rst:m_pwrite", 64'(m_pwrite_o), 64'd0);
    check("rst:m_paddr", 64'(m_paddr_o), 64'd0);
    check("rst:m_pwdata", 64'(m_pwdata_o), 64'd0);
    check("rst:m_pstrb", 64'(m_pstrb_o), 64'd0);
    check("rst:timeout", 64'(timeout_o), 64'd0);
    check("rst:err_cnt", 64'(err_cnt_o), 64'd0);
    rst_i = 0;

    xfer(32'h2000_1004, 0, 32'h0, 4'hF, 1, 32'h1234_5678, 0, 0, "can_rd");
    xfer(32'h2000_9010, 1, 32'hA5A5_A5A5, 4'hF, 1, $urandom, 0, 0, "hyp_wr");
    xfer(32'h2000_2000, 0, 32'h0, 4'hF, 1, $urandom, 0, 0, "hole_rd");
    xfer(32'h2000_7000, 0, 32'h0, 4'hF, 1000, $urandom, 0, 0, "wdt_timeout");
    xfer(32'h2000_7000, 0, 32'h0, 4'hF, 64, 32'hCAFE_F00D, 0, 0, "wdt_ready64");
    xfer(32'h2000_7004, 0, 32'h0, 4'hF, 63, 32'h0BAD_BEEF, 0, 0, "wdt_ready63");
    xfer(32'h2000_5008, 0, 32'h0, 4'hF, 2, 32'h5555_AAAA, 1, 0, "adv_slverr");
    xfer(32'h2000_1FFC, 0, 32'h0, 4'h3, 3, 32'h0F0F_0F0F, 0, 0, "can_top");
    xfer(32'h2000_0FFC, 0, 32'h0, 4'hF, 1, $urandom, 0, 0, "below_can");
    xfer(32'h2000_A000, 1, 32'h1111_2222, 4'hF, 1, $urandom, 0, 0, "above_hyp");
    xfer(32'h2000_6FFC, 0, 32'h0, 4'hF, 1, $urandom, 0, 0, "hole_6");
    xfer(32'h2000_4FFC, 0, 32'h0, 4'hF, 1, 32'h4444_0000, 0, 1, "tmr_abort");

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 3);
      if (r == 0) begin
        addr = 32'h2000_0000 + ($urandom_range(0, 32'hAFFF) & 32'hFFFF_FFFC);
      end else begin
        s = $urandom_range(0, NS - 1);
        addr = base_of(s) + ($urandom_range(0, 1023) << 2);
      end
      r = $urandom_range(0, 9);
      if (r < 6)       k = $urandom_range(1, 4);
      else if (r == 6) k = 63;
      else if (r == 7) k = 64;
      else if (r == 8) k = 65;
      else             k = $urandom_range(66, 80);
      xfer(addr, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), k, $urandom,
           1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, $sformatf("rnd%0d", t));
    end

    // Reset while the watchdog transfer is stalled in ACCESS.
    @(negedge clk);
    s_psel = 1; s_penable = 0; s_paddr = 32'h2000_7000; s_pwrite = 0;
    @(negedge clk);
    s_penable = 1;
    acc = 0;
    for (int c = 0; c < 10 && acc < 3; c++) begin
      @(negedge clk);
      m_pready = '0;
      if (m_penable_o && m_psel_o != '0) acc++;
    end
    check("rst_mid:access_reached", 64'(acc), 64'd3);
    rst_i = 1;
    @(negedge clk);
    check("rst_mid:m_psel", 64'(m_psel_o), 64'd0);
    check("rst_mid:m_penable", 64'(m_penable_o), 64'd0);
    check("rst_mid:s_pready", 64'(s_pready_o), 64'd0);
    check("rst_mid:err_cnt", 64'(err_cnt_o), 64'd0);
    rst_i = 0; s_psel = 0; s_penable = 0;
    exp_errcnt = 0;
    pr_or = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      pr_or[0] = pr_or[0] | s_pready_o;
      pr_or[1] = pr_or[1] | (m_psel_o != '0);
    end
    check("rst_mid:no_pready_after", 64'(pr_or), 64'd0);
    xfer(32'h2000_4000, 0, 32'h0, 4'hF, 1, 32'h7777_1234, 0, 0, "tmr_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
